// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: FSM encoding, default error byte and checksum helper shared by the command interface.
package uart_cmd_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_B,
    ST_GET_OP,
    ST_GET_CHK,
    ST_EXEC,
    ST_TX_START,
    ST_WAIT_TX
  } state_t;
  localparam logic [7:0] ERR_CODE_DEF = 8'hEE;
  function automatic logic chk_ok(input logic [63:0] a, input logic [63:0] b,
                                  input logic [63:0] op, input logic [63:0] chk);
    return (a ^ b ^ op) == chk;
  endfunction
endpackage

// File: rtl/frame_timer.sv
// frame_timer: saturating inter-byte cycle counter that flags when LIMIT cycles have elapsed.
module frame_timer #(
  parameter int LIMIT = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int W = $clog2(LIMIT + 1);
  logic [W-1:0] cnt_q, cnt_d;
  assign expired = cnt_q == W'(LIMIT);
  always_comb cnt_d = clear ? '0 : (enable && !expired) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
endmodule

// File: rtl/uart_cmd_interface.sv
// uart_cmd_interface: assembles A/B/opcode(/checksum) frames from a UART receiver,
// drives a combinational ALU and sends its result back through a UART transmitter.
module uart_cmd_interface
  import uart_cmd_pkg::*;
#(
  parameter int              DBIT     = 8,
  parameter int              CHK_EN   = 0,
  parameter int              TIMEOUT  = 100000,
  parameter logic [DBIT-1:0] ERR_CODE = DBIT'(ERR_CODE_DEF)
) (
  input  logic            i_clock,
  input  logic            i_reset,
  input  logic [DBIT-1:0] i_rx_data,
  input  logic            i_rx_done,
  input  logic            i_rx_ferr,
  input  logic            i_tx_done,
  output logic            o_tx_start,
  output logic [DBIT-1:0] o_tx_data,
  output logic [DBIT-1:0] o_alu_a,
  output logic [DBIT-1:0] o_alu_b,
  output logic [DBIT-1:0] o_alu_op,
  input  logic [DBIT-1:0] i_alu_result,
  output logic            o_busy,
  output logic            o_err,
  output logic            o_overrun
);
  state_t          state_q, state_d;
  logic [DBIT-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d, alu_op_q, alu_op_d, tx_data_q, tx_data_d;
  logic            chk_bad_q, chk_bad_d, err_q, err_d, overrun_q, overrun_d;
  logic            rx_state, timing, accept, expired, sum_ok;
  assign rx_state = state_q inside {ST_IDLE, ST_GET_B, ST_GET_OP, ST_GET_CHK};
  assign timing   = state_q inside {ST_GET_B, ST_GET_OP, ST_GET_CHK};
  assign sum_ok   = chk_ok(64'(alu_a_q), 64'(alu_b_q), 64'(alu_op_q), 64'(i_rx_data));
  frame_timer #(.LIMIT(TIMEOUT)) u_timer (
    .clk    (i_clock),
    .rst    (i_reset),
    .clear  (accept),
    .enable (timing),
    .expired(expired)
  );
  always_comb begin
    state_d   = state_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_op_d  = alu_op_q;
    tx_data_d = tx_data_q;
    chk_bad_d = chk_bad_q;
    err_d     = 1'b0;
    overrun_d = 1'b0;
    accept    = 1'b0;
    // a timeout wins over a byte arriving in the same cycle
    if (timing && expired) begin
      state_d = ST_IDLE;
      err_d   = 1'b1;
    end else if (rx_state && i_rx_done && i_rx_ferr) begin
      state_d = ST_IDLE;
      err_d   = 1'b1;
    end else if (rx_state && i_rx_done) begin
      accept = 1'b1;
      case (state_q)
        ST_IDLE: begin
          alu_a_d = i_rx_data;
          state_d = ST_GET_B;
        end
        ST_GET_B: begin
          alu_b_d = i_rx_data;
          state_d = ST_GET_OP;
        end
        ST_GET_OP: begin
          alu_op_d  = i_rx_data;
          chk_bad_d = 1'b0;
          state_d   = (CHK_EN != 0) ? ST_GET_CHK : ST_EXEC;
        end
        default: begin
          chk_bad_d = !sum_ok;
          err_d     = !sum_ok;
          state_d   = ST_EXEC;
        end
      endcase
    end else if (!rx_state && i_rx_done) begin
      overrun_d = 1'b1;
    end
    case (state_q)
      ST_EXEC: begin
        tx_data_d = chk_bad_q ? ERR_CODE : i_alu_result;
        state_d   = ST_TX_START;
      end
      ST_TX_START: state_d = ST_WAIT_TX;
      ST_WAIT_TX:  state_d = i_tx_done ? ST_IDLE : ST_WAIT_TX;
      default: ;
    endcase
  end
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q   <= ST_IDLE;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_op_q  <= '0;
      tx_data_q <= '0;
      chk_bad_q <= 1'b0;
      err_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_op_q  <= alu_op_d;
      tx_data_q <= tx_data_d;
      chk_bad_q <= chk_bad_d;
      err_q     <= err_d;
      overrun_q <= overrun_d;
    end
  end
  assign o_tx_start = state_q == ST_TX_START;
  assign o_busy     = state_q != ST_IDLE;
  assign o_tx_data  = tx_data_q;
  assign o_alu_a    = alu_a_q;
  assign o_alu_b    = alu_b_q;
  assign o_alu_op   = alu_op_q;
  assign o_err      = err_q;
  assign o_overrun  = overrun_q;
endmodule

// File: doc/uart_cmd_interface.md
UART_CMD_INTERFACE -- requirements
Module: uart_cmd_interface

Interface
REQ-001 SHALL have parameter DBIT, default 8: width of the data byte, operands, opcode and result.
REQ-002 SHALL have parameter CHK_EN, default 0: when 1, each frame carries a trailing XOR checksum byte.
REQ-003 SHALL have parameter TIMEOUT, default 100000: maximum clock cycles allowed between bytes of one frame.
REQ-004 SHALL have parameter ERR_CODE, default 8'hEE: byte transmitted instead of the result on checksum failure.
REQ-005 SHALL have port i_clock, input, 1: single clock for the whole block.
REQ-006 SHALL have port i_reset, input, 1: synchronous reset, active-high.
REQ-007 SHALL have port i_rx_data, input, DBIT: received byte, valid when i_rx_done=1.
REQ-008 SHALL have port i_rx_done, input, 1: one-cycle pulse per received byte.
REQ-009 SHALL have port i_rx_ferr, input, 1: framing error, sampled together with i_rx_done.
REQ-010 SHALL have port i_tx_done, input, 1: one-cycle pulse when the transmitter finishes a byte.
REQ-011 SHALL have port o_tx_start, output, 1: one-cycle pulse that launches transmission of o_tx_data.
REQ-012 SHALL have port o_tx_data, output, DBIT: byte to transmit, held stable from o_tx_start until i_tx_done.
REQ-013 SHALL have ports o_alu_a, o_alu_b and o_alu_op, outputs, DBIT each: registered operands and opcode.
REQ-014 SHALL have port i_alu_result, input, DBIT: combinational ALU result.
REQ-015 SHALL have port o_busy, output, 1: high in every state except IDLE.
REQ-016 SHALL have ports o_err and o_overrun, outputs, 1 each: one-cycle error pulses.

Function
REQ-017 SHALL implement the FSM IDLE -> GET_B -> GET_OP -> [GET_CHK if CHK_EN] -> EXEC -> TX_START -> WAIT_TX -> IDLE.
REQ-018 SHALL latch i_rx_data into o_alu_a in IDLE, o_alu_b in GET_B, and o_alu_op in GET_OP, each on i_rx_done.
REQ-019 SHALL remain in EXEC for exactly one cycle, then capture i_alu_result (or ERR_CODE) into o_tx_data on exiting EXEC.
REQ-020 SHALL assert o_tx_start for exactly one cycle in TX_START, one cycle after EXEC; latency from the final frame byte's i_rx_done to o_tx_start is 2 cycles.
REQ-021 SHALL, in WAIT_TX, hold o_tx_data until i_tx_done, then return to IDLE on the next edge.
REQ-022 SHALL, when CHK_EN=1, compare the GET_CHK byte with o_alu_a ^ o_alu_b ^ o_alu_op; on mismatch, transmit ERR_CODE and pulse o_err.
REQ-023 SHALL count cycles since the last accepted byte while in GET_B, GET_OP or GET_CHK; when the count reaches TIMEOUT, it SHALL discard the partial frame, go to IDLE and pulse o_err.
REQ-024 SHALL treat i_rx_done with i_rx_ferr=1 as a discarded byte in any receive state: go to IDLE, pulse o_err, update no operand register.
REQ-025 SHALL drop any i_rx_done arriving in EXEC, TX_START or WAIT_TX and pulse o_overrun; the state SHALL NOT change.
REQ-026 SHALL ignore i_tx_done outside WAIT_TX.
REQ-027 SHALL size the timeout counter to $clog2(TIMEOUT+1) bits and never let it wrap; it SHALL clear on every accepted byte.
REQ-028 SHALL give a timeout precedence over an i_rx_done in the same cycle (the byte is discarded).

Reset
REQ-029 SHALL, on i_reset=1 at a clock edge, go to IDLE and clear o_tx_start, o_tx_data, o_alu_a, o_alu_b, o_alu_op, o_busy, o_err, o_overrun and the timeout counter to 0.
REQ-030 SHALL, on reset mid-frame or mid-transmission, abandon the frame; the first i_rx_done after reset deasserts is byte A.

Structure
REQ-031 SHALL take the FSM state encoding, the default ERR_CODE and the checksum function from a shared package, uart_cmd_pkg.
REQ-032 SHALL place the inter-byte timeout counter in one sub-module, frame_timer (inputs: clear, enable; output: expired).

Verification
REQ-033 SHALL cover: CHK_EN=0, frame 0x14, 0x07, 0x20 with an add ALU -> o_tx_start 2 cycles after the third i_rx_done and o_tx_data=0x1B.
REQ-034 SHALL cover: CHK_EN=1, frame 0x14, 0x07, 0x20, 0x33 -> o_tx_data=0x1B and o_err stays 0.
REQ-035 SHALL cover: CHK_EN=1, frame 0x14, 0x07, 0x20, 0x00 -> o_tx_data=0xEE and a single o_err pulse.
REQ-036 SHALL cover: TIMEOUT=1000, send 0x14 and then wait 1000 cycles -> o_err pulse, IDLE; then 0x05, 0x03, 0x20 -> 0x08.
REQ-037 SHALL cover: i_rx_done during WAIT_TX -> o_overrun pulse, and the o_tx_data value is unchanged.
REQ-038 SHALL cover: i_rx_ferr=1 on byte B -> o_err pulse, o_alu_b unchanged, FSM in IDLE; reset asserted in GET_OP -> all outputs 0.
